alu_decoder_unit: RTL and testbench
===================================

ALU_DECODER_UNIT -- requirements
Module: alu_decoder_unit

Interface
REQ-001 Parameter DIV_HALF, default 4, orig_clk rising edges per half-period of clk_slow; legal range 1..255.
REQ-002 orig_clk  in  1  single system clock; all state changes on its rising edge.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 instruction  in  32  instruction word to decode.
REQ-005 data_a  in  32  ALU operand A (register rs value).
REQ-006 data_b  in  32  ALU operand B (register rt value).
REQ-007 op  out  2  decoded instr[31:30], combinational.
REQ-008 fn  out  4  decoded instr[29:26], combinational.
REQ-009 rs  out  5  decoded instr[25:21], combinational.
REQ-010 rt  out  5  decoded instr[20:16], combinational.
REQ-011 imm  out  26  decoded immediate, combinational (REQ-014).
REQ-012 result_low / result_high  out  32 each  registered ALU result.
REQ-013 zflag, carryflag, signflag, overflowflag  out  1 each  registered status flags; clk_slow  out  1  divided clock.

Function
REQ-014 imm: op=10 or 11 -> instr[25:0]; op=00 -> instr[20:0] sign-extended to 26 bits; op=01 -> instr[15:0] sign-extended to 26 bits.
REQ-015 Operand B (B): op=00 -> imm sign-extended to 32 bits; op=01 fn 1001/1010 -> imm sign-extended to 32; other op=01 -> data_b.
REQ-016 op=00: fn 0000 A+B; 0001 -B (two's complement); 0010 A<<B[4:0]; 0011 A>>B[4:0] logical; 0100 A>>>B[4:0] arithmetic; other fn -> zero result, flags held.
REQ-017 op=01: fn 0000 A+B; 0001 unsigned 32x32->64 multiply; 0010 signed multiply; 0011 -B; 0100 A&B; 0101 A^B; 0110 A<<B[4:0]; 0111 A>>B[4:0] logical; 1000 A>>>B[4:0]; 1001/1010 A+B address; other fn -> zero result, flags held.
REQ-018 op=10 or 11: result_low=result_high=0; flags held.
REQ-019 Multiply: result_high=product[63:32], result_low=product[31:0]; signflag=product[63]; zflag=(product==0); carry/overflow cleared.
REQ-020 Add (A+B incl. address): result_low=sum[31:0]; result_high={31'b0,carry}; carryflag=bit 32 of unsigned sum; overflowflag=1 when A,B same sign and sum sign differs.
REQ-021 Non-add, non-multiply ops: result_high=0; carry/overflow cleared.
REQ-022 zflag=(result_low==0) and signflag=result_low[31] for every flag-updating non-multiply op.
REQ-023 Latency exactly 1 cycle: result/flags reflect the instruction, data_a, data_b sampled at the previous orig_clk rising edge.
REQ-024 Shift amounts use B[4:0] only; shift by 0 passes A unchanged.
REQ-025 -B of 0x80000000 yields 0x80000000, overflowflag=1.
REQ-026 clk_slow: internal counter increments each rising edge; on reaching DIV_HALF-1, counter returns to 0 and clk_slow toggles; period = 2*DIV_HALF orig_clk cycles, 50% duty.
REQ-027 clk_slow is a register output only, never used to clock internal logic.

Reset
REQ-028 rst_n low immediately forces result_low, result_high, all flags, clk_slow and divider counter to 0, independent of orig_clk.
REQ-029 While rst_n low, decode outputs remain combinational and valid.
REQ-030 After rst_n rises, first update occurs on the next rising edge; clk_slow first toggles to 1 after DIV_HALF rising edges.
REQ-031 Reset asserted mid-operation discards any pending result; no partial state survives.

Verification
REQ-032 op=00 fn=0000 data_a=5, instr[20:0]=0x1FFFFD (-3) -> next cycle result_low=2, carryflag=1, zflag=0, signflag=0.
REQ-033 op=01 fn=0010 data_a=0xFFFFFFFF, data_b=2 -> result_high=0xFFFFFFFF, result_low=0xFFFFFFFE, signflag=1; fn=0001 same operands -> result_high=1, result_low=0xFFFFFFFE.
REQ-034 op=01 fn=0000 data_a=0x7FFFFFFF, data_b=1 -> result_low=0x80000000, overflowflag=1, signflag=1, carryflag=0.
REQ-035 op=01 fn=1000 data_a=0x80000000, data_b=4 -> result_low=0xF8000000; fn=0101 data_a=data_b=0xA5A5A5A5 -> result_low=0, zflag=1.
REQ-036 instruction=0x8000_00FF (op=10) -> op=2, fn=0, imm=0x0000FF combinational, result_low=0, flags unchanged.
REQ-037 DIV_HALF=4: clk_slow toggles every 4 edges (period 8); rst_n pulsed low mid-period -> clk_slow and result outputs 0 at once, count restarts.

Source files
------------

// File: rtl/alu_decoder_unit_if.sv
// Bus bundle for alu_decoder_unit: instruction/operands in, decode fields,
// registered ALU results, status flags and the divided clock out.
interface alu_decoder_unit_if;
    logic [31:0] instruction;
    logic [31:0] data_a;
    logic [31:0] data_b;
    logic [1:0]  op;
    logic [3:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [25:0] imm;
    logic [31:0] result_low;
    logic [31:0] result_high;
    logic        zflag;
    logic        carryflag;
    logic        signflag;
    logic        overflowflag;
    logic        clk_slow;

    // Driver side: supplies instruction and operands, observes everything else
    modport master (
        output instruction, data_a, data_b,
        input  op, fn, rs, rt, imm,
        input  result_low, result_high,
        input  zflag, carryflag, signflag, overflowflag, clk_slow
    );

    // Unit side: consumes instruction and operands, produces decode/results
    modport slave (
        input  instruction, data_a, data_b,
        output op, fn, rs, rt, imm,
        output result_low, result_high,
        output zflag, carryflag, signflag, overflowflag, clk_slow
    );
endinterface

// File: rtl/alu_decoder_unit.sv
// Instruction decoder with a one-cycle registered ALU and a clock divider.
// Decode fields are combinational; results, flags and clk_slow are registers.
module alu_decoder_unit #(
    parameter int unsigned DIV_HALF = 4
) (
    input  logic              orig_clk,
    input  logic              rst_n,
    alu_decoder_unit_if.slave bus
);

    localparam int unsigned DW = 32;
    localparam int unsigned PW = 64;
    localparam int unsigned CW = 8;

    typedef enum logic [1:0] {
        K_HOLD  = 2'd0,
        K_ADD   = 2'd1,
        K_MUL   = 2'd2,
        K_LOGIC = 2'd3
    } alu_kind_e;

    logic [1:0]    op;
    logic [3:0]    fn;
    logic [25:0]   imm;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] imm_sx;
    logic [4:0]    shamt;
    logic [DW:0]   sum;
    logic [PW-1:0] prod_u;
    logic [PW-1:0] prod_s;

    alu_kind_e     kind;
    logic          use_signed;
    logic          neg_ovf;
    logic [DW-1:0] logic_res;

    logic [DW-1:0] nxt_low;
    logic [DW-1:0] nxt_high;
    logic          nxt_z;
    logic          nxt_c;
    logic          nxt_s;
    logic          nxt_o;

    logic [CW-1:0] div_cnt;

    // Field extraction and immediate formation, valid even while in reset
    always_comb begin
        op  = bus.instruction[31:30];
        fn  = bus.instruction[29:26];
        imm = bus.instruction[25:0];
        unique case (op)
            2'b00:   imm = {{5{bus.instruction[20]}}, bus.instruction[20:0]};
            2'b01:   imm = {{10{bus.instruction[15]}}, bus.instruction[15:0]};
            default: imm = bus.instruction[25:0];
        endcase
    end

    assign bus.op  = op;
    assign bus.fn  = fn;
    assign bus.rs  = bus.instruction[25:21];
    assign bus.rt  = bus.instruction[20:16];
    assign bus.imm = imm;

    assign a      = bus.data_a;
    assign imm_sx = {{6{imm[25]}}, imm};

    // Operand B: immediate for op 00 and the op 01 address forms, else rt value
    always_comb begin
        b = bus.data_b;
        if (op == 2'b00) begin
            b = imm_sx;
        end else if (op == 2'b01 && (fn == 4'b1001 || fn == 4'b1010)) begin
            b = imm_sx;
        end
    end

    assign shamt  = b[4:0];
    assign sum    = {1'b0, a} + {1'b0, b};
    assign prod_u = {32'b0, a} * {32'b0, b};
    assign prod_s = $unsigned($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));

    // Opcode classification and the result of single-word operations
    always_comb begin
        kind       = K_HOLD;
        use_signed = 1'b0;
        neg_ovf    = 1'b0;
        logic_res  = '0;
        unique case (op)
            2'b00: begin
                unique case (fn)
                    4'b0000: kind = K_ADD;
                    4'b0001: begin
                        kind      = K_LOGIC;
                        logic_res = DW'(0) - b;
                        neg_ovf   = (b == 32'h8000_0000);
                    end
                    4'b0010: begin
                        kind      = K_LOGIC;
                        logic_res = a << shamt;
                    end
                    4'b0011: begin
                        kind      = K_LOGIC;
                        logic_res = a >> shamt;
                    end
                    4'b0100: begin
                        kind      = K_LOGIC;
                        logic_res = $unsigned($signed(a) >>> shamt);
                    end
                    default: kind = K_HOLD;
                endcase
            end
            2'b01: begin
                unique case (fn)
                    4'b0000, 4'b1001, 4'b1010: kind = K_ADD;
                    4'b0001: kind = K_MUL;
                    4'b0010: begin
                        kind       = K_MUL;
                        use_signed = 1'b1;
                    end
                    4'b0011: begin
                        kind      = K_LOGIC;
                        logic_res = DW'(0) - b;
                        neg_ovf   = (b == 32'h8000_0000);
                    end
                    4'b0100: begin
                        kind      = K_LOGIC;
                        logic_res = a & b;
                    end
                    4'b0101: begin
                        kind      = K_LOGIC;
                        logic_res = a ^ b;
                    end
                    4'b0110: begin
                        kind      = K_LOGIC;
                        logic_res = a << shamt;
                    end
                    4'b0111: begin
                        kind      = K_LOGIC;
                        logic_res = a >> shamt;
                    end
                    4'b1000: begin
                        kind      = K_LOGIC;
                        logic_res = $unsigned($signed(a) >>> shamt);
                    end
                    default: kind = K_HOLD;
                endcase
            end
            default: kind = K_HOLD;
        endcase
    end

    // Next result and flag values; K_HOLD zeroes results and keeps flags
    always_comb begin
        nxt_low  = '0;
        nxt_high = '0;
        nxt_z    = bus.zflag;
        nxt_c    = bus.carryflag;
        nxt_s    = bus.signflag;
        nxt_o    = bus.overflowflag;
        unique case (kind)
            K_ADD: begin
                nxt_low  = sum[DW-1:0];
                nxt_high = {31'b0, sum[DW]};
                nxt_c    = sum[DW];
                nxt_o    = (a[31] == b[31]) && (sum[31] != a[31]);
                nxt_z    = (sum[DW-1:0] == '0);
                nxt_s    = sum[31];
            end
            K_MUL: begin
                nxt_low  = use_signed ? prod_s[31:0]  : prod_u[31:0];
                nxt_high = use_signed ? prod_s[63:32] : prod_u[63:32];
                nxt_c    = 1'b0;
                nxt_o    = 1'b0;
                nxt_z    = use_signed ? (prod_s == '0) : (prod_u == '0);
                nxt_s    = use_signed ? prod_s[63] : prod_u[63];
            end
            K_LOGIC: begin
                nxt_low  = logic_res;
                nxt_high = '0;
                nxt_c    = 1'b0;
                nxt_o    = neg_ovf;
                nxt_z    = (logic_res == '0);
                nxt_s    = logic_res[31];
            end
            default: begin
                nxt_low  = '0;
                nxt_high = '0;
            end
        endcase
    end

    // Result and flag registers, one-cycle latency
    always_ff @(posedge orig_clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.result_low   <= '0;
            bus.result_high  <= '0;
            bus.zflag        <= 1'b0;
            bus.carryflag    <= 1'b0;
            bus.signflag     <= 1'b0;
            bus.overflowflag <= 1'b0;
        end else begin
            bus.result_low   <= nxt_low;
            bus.result_high  <= nxt_high;
            bus.zflag        <= nxt_z;
            bus.carryflag    <= nxt_c;
            bus.signflag     <= nxt_s;
            bus.overflowflag <= nxt_o;
        end
    end

    // Divider: toggle clk_slow every DIV_HALF edges; output only, never a clock
    always_ff @(posedge orig_clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt      <= '0;
            bus.clk_slow <= 1'b0;
        end else if (div_cnt == CW'(DIV_HALF - 1)) begin
            div_cnt      <= '0;
            bus.clk_slow <= ~bus.clk_slow;
        end else begin
            div_cnt      <= div_cnt + CW'(1);
        end
    end

endmodule

// File: tb/tb_alu_decoder_unit.sv
// Directed bench for alu_decoder_unit: decode, ALU ops, flags, latency,
// divided clock and asynchronous reset.
module tb_alu_decoder_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_decoder_unit_if bus ();

    alu_decoder_unit #(.DIV_HALF(4)) dut (
        .orig_clk (clk),
        .rst_n    (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one vector at a falling edge and return #1 after the next rising edge
    task automatic apply(input logic [31:0] ins, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        bus.instruction = ins;
        bus.data_a      = av;
        bus.data_b      = bv;
        @(posedge clk);
        #1;
    endtask

    // Combinational decode fields for a table of instruction words
    task automatic test_decode();
        logic [31:0] ins [6];
        logic [41:0] ex  [6];
        logic [41:0] obs;
        ins = '{32'h001F_FFFD, 32'h4067_8001, 32'h4067_7FFF,
                32'h000F_FFFF, 32'hC3FF_FFFF, 32'h7FFF_FFFF};
        ex  = '{{2'd0, 4'h0, 5'd0,  5'd31, 26'h3FF_FFFD},
                {2'd1, 4'h0, 5'd3,  5'd7,  26'h3FF_8001},
                {2'd1, 4'h0, 5'd3,  5'd7,  26'h000_7FFF},
                {2'd0, 4'h0, 5'd0,  5'd15, 26'h00F_FFFF},
                {2'd3, 4'h0, 5'd31, 5'd31, 26'h3FF_FFFF},
                {2'd1, 4'hF, 5'd31, 5'd31, 26'h3FF_FFFF}};
        for (int i = 0; i < 6; i++) begin
            bus.instruction = ins[i];
            #1;
            obs = {bus.op, bus.fn, bus.rs, bus.rt, bus.imm};
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL decode[%0d] instr=%h got=%h expected=%h", i, ins[i], obs, ex[i]);
            end
        end
    endtask

    // Outputs held at zero during reset even with a live add and running clock
    task automatic test_reset();
        logic [68:0] obs;
        rst_n           = 1'b0;
        bus.instruction = 32'h4000_0000;
        bus.data_a      = 32'h0000_1234;
        bus.data_b      = 32'h0000_0001;
        repeat (3) @(posedge clk);
        #1;
        obs = {bus.result_high, bus.result_low, bus.zflag, bus.carryflag,
               bus.signflag, bus.overflowflag, bus.clk_slow};
        checks++;
        if (obs !== 69'd0) begin
            errors++;
            $display("FAIL reset_state got=%h expected=0", obs);
        end
        test_decode();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // op=00 forms with immediate operand B
    task automatic test_op00();
        logic [31:0] ins [7];
        logic [31:0] av  [7];
        logic [67:0] ex  [7];
        logic [67:0] obs;
        ins = '{32'h001F_FFFD, 32'h0400_0005, 32'h0800_001F, 32'h0C00_0004,
                32'h1000_0004, 32'h1C00_0000, 32'h0400_0000};
        av  = '{32'd5, 32'd0, 32'd1, 32'h8000_0000,
                32'h8000_0000, 32'hFFFF_FFFF, 32'd9};
        ex  = '{{32'h1, 32'h0000_0002, 4'b0100},
                {32'h0, 32'hFFFF_FFFB, 4'b0010},
                {32'h0, 32'h8000_0000, 4'b0010},
                {32'h0, 32'h0800_0000, 4'b0000},
                {32'h0, 32'hF800_0000, 4'b0010},
                {32'h0, 32'h0000_0000, 4'b0010},
                {32'h0, 32'h0000_0000, 4'b1000}};
        for (int i = 0; i < 7; i++) begin
            apply(ins[i], av[i], 32'hDEAD_BEEF);
            obs = {bus.result_high, bus.result_low, bus.zflag, bus.carryflag,
                   bus.signflag, bus.overflowflag};
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL op00[%0d] instr=%h got=%h expected=%h", i, ins[i], obs, ex[i]);
            end
        end
    endtask

    // op=01 register forms, multiplies, address adds and an undefined fn
    task automatic test_op01();
        logic [31:0] ins [13];
        logic [31:0] av  [13];
        logic [31:0] bv  [13];
        logic [67:0] ex  [13];
        logic [67:0] obs;
        ins = '{32'h4800_0000, 32'h4400_0000, 32'h4000_0000, 32'h6000_0000,
                32'h5400_0000, 32'h4C00_0000, 32'h5000_0000, 32'h5800_0000,
                32'h5C00_0000, 32'h6400_FFFF, 32'h7C00_0000, 32'h6800_0010,
                32'h4800_0000};
        av  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000,
                32'hA5A5_A5A5, 32'h0,         32'hF0F0_F0F0, 32'h0000_1234,
                32'h8000_0000, 32'h0000_0100, 32'h1,         32'h0000_0010,
                32'h0};
        bv  = '{32'h2,         32'h2,         32'h1,         32'h4,
                32'hA5A5_A5A5, 32'h8000_0000, 32'hFF00_FF00, 32'h0000_0020,
                32'h0000_001F, 32'hDEAD_BEEF, 32'h1,         32'hDEAD_BEEF,
                32'h5};
        ex  = '{{32'hFFFF_FFFF, 32'hFFFF_FFFE, 4'b0010},
                {32'h0000_0001, 32'hFFFF_FFFE, 4'b0000},
                {32'h0,         32'h8000_0000, 4'b0011},
                {32'h0,         32'hF800_0000, 4'b0010},
                {32'h0,         32'h0000_0000, 4'b1000},
                {32'h0,         32'h8000_0000, 4'b0011},
                {32'h0,         32'hF000_F000, 4'b0010},
                {32'h0,         32'h0000_1234, 4'b0000},
                {32'h0,         32'h0000_0001, 4'b0000},
                {32'h1,         32'h0000_00FF, 4'b0100},
                {32'h0,         32'h0000_0000, 4'b0100},
                {32'h0,         32'h0000_0020, 4'b0000},
                {32'h0,         32'h0000_0000, 4'b1000}};
        for (int i = 0; i < 13; i++) begin
            apply(ins[i], av[i], bv[i]);
            obs = {bus.result_high, bus.result_low, bus.zflag, bus.carryflag,
                   bus.signflag, bus.overflowflag};
            checks++;
            if (obs !== ex[i]) begin
                errors++;
                $display("FAIL op01[%0d] instr=%h got=%h expected=%h", i, ins[i], obs, ex[i]);
            end
        end
    endtask

    // op=10/11: zero results, flags held from the preceding add
    task automatic test_op10_hold();
        logic [67:0] obs;
        logic [31:0] dec;
        apply(32'h4000_0000, 32'hFFFF_FFFF, 32'h1);
        obs = {bus.result_high, bus.result_low, bus.zflag, bus.carryflag,
               bus.signflag, bus.overflowflag};
        checks++;
        if (obs !== {32'h1, 32'h0, 4'b1100}) begin
            errors++;
            $display("FAIL wrap_add got=%h expected=%h", obs, {32'h1, 32'h0, 4'b1100});
        end
        apply(32'h8000_00FF, 32'h1234_5678, 32'h1);
        dec = {bus.op, bus.fn, bus.imm};
        checks++;
        if (dec !== {2'd2, 4'h0, 26'h00_00FF}) begin
            errors++;
            $display("FAIL op10_decode got=%h expected=%h", dec, {2'd2, 4'h0, 26'h00_00FF});
        end
        obs = {bus.result_high, bus.result_low, bus.zflag, bus.carryflag,
               bus.signflag, bus.overflowflag};
        checks++;
        if (obs !== {32'h0, 32'h0, 4'b1100}) begin
            errors++;
            $display("FAIL op10_hold got=%h expected=%h", obs, {32'h0, 32'h0, 4'b1100});
        end
        apply(32'hC3FF_FFFF, 32'h1, 32'h1);
        obs = {bus.result_high, bus.result_low, bus.zflag, bus.carryflag,
               bus.signflag, bus.overflowflag};
        checks++;
        if (obs !== {32'h0, 32'h0, 4'b1100}) begin
            errors++;
            $display("FAIL op11_hold got=%h expected=%h", obs, {32'h0, 32'h0, 4'b1100});
        end
    endtask

    // Result changes only at the edge after the operands change
    task automatic test_back_to_back();
        apply(32'h4000_0000, 32'd3, 32'd4);
        checks++;
        if (bus.result_low !== 32'd7) begin
            errors++;
            $display("FAIL b2b_first got=%h expected=%h", bus.result_low, 32'd7);
        end
        @(negedge clk);
        bus.data_a = 32'd10;
        bus.data_b = 32'd20;
        #1;
        checks++;
        if (bus.result_low !== 32'd7) begin
            errors++;
            $display("FAIL b2b_hold got=%h expected=%h", bus.result_low, 32'd7);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.result_low !== 32'd30) begin
            errors++;
            $display("FAIL b2b_second got=%h expected=%h", bus.result_low, 32'd30);
        end
    endtask

    // Divider period from reset, then an asynchronous reset mid-period
    task automatic test_clk_div();
        logic       exp_slow;
        logic [64:0] obs;
        @(negedge clk);
        rst_n           = 1'b0;
        bus.instruction = 32'h4000_0000;
        bus.data_a      = 32'd1;
        bus.data_b      = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 22; k++) begin
            @(posedge clk);
            #1;
            exp_slow = ((k / 4) % 2) == 1;
            checks++;
            if (bus.clk_slow !== exp_slow) begin
                errors++;
                $display("FAIL clk_slow edge=%0d got=%b expected=%b", k, bus.clk_slow, exp_slow);
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        obs = {bus.result_high, bus.result_low, bus.clk_slow};
        checks++;
        if (obs !== 65'd0) begin
            errors++;
            $display("FAIL async_reset got=%h expected=0", obs);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk);
            #1;
            exp_slow = (k >= 4);
            checks++;
            if (bus.clk_slow !== exp_slow || bus.result_low !== 32'd1) begin
                errors++;
                $display("FAIL restart edge=%0d clk_slow=%b result_low=%h expected clk_slow=%b result_low=1",
                         k, bus.clk_slow, bus.result_low, exp_slow);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        bus.instruction = '0;
        bus.data_a      = '0;
        bus.data_b      = '0;
        test_reset();
        test_op00();
        test_op01();
        test_op10_hold();
        test_back_to_back();
        test_clk_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time bound so the run always terminates
    initial begin
        #200000;
        $display("FAIL timeout reached without completion");
        $fatal(1);
    end

endmodule
